// File: rtl/dsp_pkg.sv
// dsp_pkg: shared DSP widths and frame-accumulator state encodings.
package dsp_pkg;
   localparam int P_W  = 48;
   localparam int AB_W = 18;
   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_ACCUM = 2'd1,
      ST_HOLD  = 2'd2
   } state_t;
endpackage

// File: rtl/dsp_shift_sat.sv
// dsp_shift_sat: arithmetic right shift of the frame sum, then clip (DSP_ACC_SAT_EN) or wrap to OUT_W.
module dsp_shift_sat #(
   parameter int ACC_W = 56,
   parameter int OUT_W = 48,
   parameter int SHIFT = 0
) (
   input  logic signed [ACC_W-1:0] i_sum,
   output logic        [OUT_W-1:0] o_data,
   output logic                    o_sat
);
   logic signed [ACC_W-1:0] w_s;
   assign w_s = i_sum >>> SHIFT;
`ifdef DSP_ACC_SAT_EN
   localparam logic [OUT_W-1:0] MAXV = {OUT_W{1'b1}} >> 1;
   localparam logic [OUT_W-1:0] MINV = ~MAXV;
   logic [ACC_W-OUT_W:0] w_hi;
   logic                 w_ovf;
   // The value fits iff every bit above the OUT_W sign bit copies it.
   assign w_hi   = w_s[ACC_W-1:OUT_W-1];
   assign w_ovf  = !((&w_hi) || !(|w_hi));
   assign o_data = w_ovf ? (w_s[ACC_W-1] ? MINV : MAXV) : w_s[OUT_W-1:0];
   assign o_sat  = w_ovf;
`else
   logic w_unused_hi;
   assign w_unused_hi = ^w_s;
   assign o_data      = w_s[OUT_W-1:0];
   assign o_sat       = 1'b0;
`endif
endmodule

// File: rtl/dsp_frame_accumulator.sv
// dsp_frame_accumulator: sums FRAME_LEN signed P samples, scales, hands off over valid/ready.
// Optional clipping with out_sat is enabled by defining DSP_ACC_SAT_EN.
module dsp_frame_accumulator
   import dsp_pkg::*;
#(
   parameter int LEN_W = 8,
   parameter int SHIFT = 0,
   parameter int OUT_W = 48
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   input  logic [P_W-1:0]   in_p,
   output logic             in_ready,
   input  logic [LEN_W-1:0] frame_len,
   output logic             out_valid,
   output logic [OUT_W-1:0] out_data,
   output logic             out_sat,
   input  logic             out_ready
);
   localparam int ACC_W = P_W + LEN_W;

   state_t             r_state;
   logic [ACC_W-1:0]   r_acc;
   logic [LEN_W-1:0]   r_cnt;
   logic [LEN_W-1:0]   r_len_q;
   logic               r_out_valid;
   logic [OUT_W-1:0]   r_out_data;
   logic               r_out_sat;

   logic               w_accept;
   logic               w_idle;
   logic               w_last;
   logic [LEN_W-1:0]   w_len_eff;
   logic [ACC_W-1:0]   w_in_ext;
   logic [ACC_W-1:0]   w_sum;
   logic [OUT_W-1:0]   w_data;
   logic               w_sat;

   assign in_ready  = r_state != ST_HOLD;
   assign w_accept  = in_valid && in_ready;
   assign w_idle    = r_state == ST_IDLE;
   assign w_len_eff = (frame_len == '0) ? LEN_W'(1) : frame_len;
   assign w_in_ext  = {{LEN_W{in_p[P_W-1]}}, in_p};
   assign w_sum     = (w_idle ? '0 : r_acc) + w_in_ext;
   // cnt < len_q throughout ACCUM, so cnt+1 cannot wrap.
   assign w_last    = w_idle ? (w_len_eff == LEN_W'(1)) : (r_cnt + 1'b1 == r_len_q);

   dsp_shift_sat #(
      .ACC_W(ACC_W),
      .OUT_W(OUT_W),
      .SHIFT(SHIFT)
   ) u_shift_sat (
      .i_sum (w_sum),
      .o_data(w_data),
      .o_sat (w_sat)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state     <= ST_IDLE;
         r_acc       <= '0;
         r_cnt       <= '0;
         r_len_q     <= '0;
         r_out_valid <= 1'b0;
         r_out_data  <= '0;
         r_out_sat   <= 1'b0;
      end else begin
         case (r_state)
            ST_IDLE, ST_ACCUM: begin
               if (w_accept) begin
                  r_acc <= w_sum;
                  r_cnt <= w_idle ? LEN_W'(1) : r_cnt + 1'b1;
                  if (w_idle)
                     r_len_q <= w_len_eff;
                  if (w_last) begin
                     r_state     <= ST_HOLD;
                     r_out_valid <= 1'b1;
                     r_out_data  <= w_data;
                     r_out_sat   <= w_sat;
                  end else begin
                     r_state <= ST_ACCUM;
                  end
               end
            end
            ST_HOLD: begin
               if (out_ready) begin
                  r_state     <= ST_IDLE;
                  r_out_valid <= 1'b0;
                  r_acc       <= '0;
                  r_cnt       <= '0;
               end
            end
            default: r_state <= ST_IDLE;
         endcase
      end
   end

   assign out_valid = r_out_valid;
   assign out_data  = r_out_data;
   assign out_sat   = r_out_sat;
endmodule

// File: tb/tb_dsp_frame_accumulator.sv
// tb_dsp_frame_accumulator: three parameterisations share one stimulus stream and one frame-level model.
module tb_dsp_frame_accumulator;
   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        in_valid = 1'b0;
   logic [47:0] in_p = '0;
   logic [7:0]  frame_len = '0;
   logic        out_ready = 1'b0;

   logic        rdy0, rdy1, rdy2;
   logic        v0, v1, v2;
   logic        s0, s1, s2;
   logic [47:0] d0;
   logic [17:0] d1, d2;

   int n_chk = 0;
   int n_fail = 0;

   always #5 clk = ~clk;

   dsp_frame_accumulator #(.LEN_W(8), .SHIFT(0), .OUT_W(48)) u0 (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_p(in_p), .in_ready(rdy0),
      .frame_len(frame_len), .out_valid(v0), .out_data(d0), .out_sat(s0), .out_ready(out_ready));
   dsp_frame_accumulator #(.LEN_W(8), .SHIFT(0), .OUT_W(18)) u1 (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_p(in_p), .in_ready(rdy1),
      .frame_len(frame_len), .out_valid(v1), .out_data(d1), .out_sat(s1), .out_ready(out_ready));
   dsp_frame_accumulator #(.LEN_W(8), .SHIFT(2), .OUT_W(18)) u2 (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_p(in_p), .in_ready(rdy2),
      .frame_len(frame_len), .out_valid(v2), .out_data(d2), .out_sat(s2), .out_ready(out_ready));

   task automatic chk(input string nm, input longint act, input longint exp);
      n_chk++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d", nm, act, exp);
      end
   endtask

   function automatic longint fit(input longint s, input int sh, input int ow, output bit sat);
      longint v, hi, lo;
      v   = s >>> sh;
      hi  = (longint'(1) <<< (ow - 1)) - 1;
      lo  = -hi - 1;
      sat = 1'b0;
`ifdef DSP_ACC_SAT_EN
      if (v > hi) begin v = hi; sat = 1'b1; end
      else if (v < lo) begin v = lo; sat = 1'b1; end
`else
      if (ow < 64) v = (v <<< (64 - ow)) >>> (64 - ow);
`endif
      return v;
   endfunction

   // Frame-level model: pending result, current frame count/length/sum.
   bit     m_hold = 1'b0;
   int     m_cnt = 0;
   int     m_len = 0;
   longint m_sum = 0;
   longint m_res = 0;

   always @(negedge clk) begin
      longint act_d[3];
      bit     act_v[3], act_r[3], act_s[3];
      int     ow[3], sh[3];
      longint e;
      bit     es;
      ow = '{48, 18, 18};
      sh = '{0, 0, 2};
      act_d[0] = $signed(d0); act_d[1] = $signed(d1); act_d[2] = $signed(d2);
      act_v = '{v0, v1, v2};
      act_r = '{rdy0, rdy1, rdy2};
      act_s = '{s0, s1, s2};
      if (!rst_n) begin
         m_hold = 1'b0; m_cnt = 0; m_sum = 0;
         for (int k = 0; k < 3; k++) begin
            chk($sformatf("rst_valid%0d", k), act_v[k], 0);
            chk($sformatf("rst_ready%0d", k), act_r[k], 1);
            chk($sformatf("rst_data%0d", k), act_d[k], 0);
            chk($sformatf("rst_sat%0d", k), act_s[k], 0);
         end
      end else begin
         for (int k = 0; k < 3; k++) begin
            chk($sformatf("ready%0d", k), act_r[k], !m_hold);
            chk($sformatf("valid%0d", k), act_v[k], m_hold);
            if (m_hold) begin
               e = fit(m_res, sh[k], ow[k], es);
               chk($sformatf("data%0d", k), act_d[k], e);
               chk($sformatf("sat%0d", k), act_s[k], es);
            end
         end
         if (m_hold) begin
            if (out_ready) m_hold = 1'b0;
         end else if (in_valid) begin
            if (m_cnt == 0) begin
               m_len = (frame_len == 0) ? 1 : int'(frame_len);
               m_sum = 0;
            end
            m_sum += longint'($signed(in_p));
            m_cnt++;
            if (m_cnt == m_len) begin
               m_res  = m_sum;
               m_hold = 1'b1;
               m_cnt  = 0;
            end
         end
      end
   end

   task automatic send(input longint p, input int len);
      in_valid  = 1'b1;
      in_p      = p[47:0];
      frame_len = len[7:0];
      @(posedge clk); #1;
      in_valid  = 1'b0;
   endtask

   task automatic idle(input int n);
      repeat (n) begin @(posedge clk); #1; end
   endtask

   task automatic pop();
      int n = 0;
      while (!v0 && n < 20) begin @(posedge clk); #1; n++; end
      if (!v0) chk("pop_timeout", 0, 1);
      out_ready = 1'b1;
      @(posedge clk); #1;
      out_ready = 1'b0;
      chk("pop_valid_drop", v0, 0);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1);
   end

   initial begin
      idle(3);
      chk("t1_valid", v0, 0);
      chk("t1_data", $signed(d0), 0);
      chk("t1_ready", rdy0, 1);
      rst_n = 1'b1;
      idle(2);
      chk("t1_no_spurious", v0, 0);

      send(5, 4); send(6, 4); send(7, 4);
      chk("t2_not_early", v0, 0);
      send(8, 4);
      chk("t2_valid", v0, 1);
      chk("t2_data", $signed(d0), 26);
      in_valid = 1'b1; in_p = 48'd99;
      idle(3);
      chk("t2_stable", $signed(d0), 26);
      chk("t2_ready_low", rdy0, 0);
      in_valid = 1'b0;
      pop();

      send(-3, 0);
      chk("t3_valid", v0, 1);
      chk("t3_data", $signed(d0), -3);
      pop();

      send(-10, 3); idle(2);
      send(4, 9); idle(2);
      chk("t4_not_early", v0, 0);
      send(-1, 9);
      chk("t4_data", $signed(d0), -7);
      pop();

      send(200000, 2); send(200000, 2);
      chk("t5_full", $signed(d0), 400000);
`ifdef DSP_ACC_SAT_EN
      chk("t5_clip_data", $signed(d1), 131071);
      chk("t5_clip_sat", s1, 1);
`else
      chk("t5_wrap_data", $signed(d1), -124288);
      chk("t5_wrap_sat", s1, 0);
`endif
      chk("t5_shift_big", $signed(d2), 100000);
      pop();
      send(8, 2); send(8, 2);
      chk("t5_shift", $signed(d2), 4);
      chk("t5_noshift", $signed(d1), 16);
      pop();

      send(1, 4); send(2, 4);
      rst_n = 1'b0;
      idle(1);
      chk("t6_rst_valid", v0, 0);
      rst_n = 1'b1;
      idle(1);
      chk("t6_no_output", v0, 0);
      send(1, 2); send(2, 2);
      chk("t6_data", $signed(d0), 3);
      pop();
      idle(2);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
